// File: rtl/bkg_sub_pkg.sv
// Shared encodings for the background-subtraction frame sequencer:
// frame modes, sequencer states and the default frame length.
package bkg_sub_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_CLEAR  = 2'd1,
        MODE_ACCUM  = 2'd2,
        MODE_APPLY  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ACCUM = 2'd2,
        ST_APPLY = 2'd3
    } state_t;

    localparam int WORDS_PER_FRAME_DEF = 163;

    function automatic mode_t mode_of(input state_t s);
        case (s)
            ST_CLEAR: return MODE_CLEAR;
            ST_ACCUM: return MODE_ACCUM;
            ST_APPLY: return MODE_APPLY;
            default:  return MODE_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/bkg_frame_checker.sv
// Taps the input stream handshake, tracks frame boundaries and reports
// single-cycle strobes for SOP beats and for good/bad frame endings.
module bkg_frame_checker
    import bkg_sub_pkg::*;
#(
    parameter int WORDS_PER_FRAME = WORDS_PER_FRAME_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mon_valid,
    input  logic mon_ready,
    input  logic mon_sop,
    input  logic mon_eop,
    output logic sop_beat,
    output logic good_end,
    output logic bad_end
);

    logic [8:0] beat_cnt;
    logic       in_frame;
    logic       beat;
    logic       len_ok;

    assign beat   = mon_valid & mon_ready;
    assign len_ok = (({1'b0, beat_cnt} + 10'd1) == 10'(WORDS_PER_FRAME));

    // An SOP inside a frame closes the previous frame as bad; SOP+EOP is a 1-beat frame.
    always_comb begin
        sop_beat = beat & mon_sop;
        good_end = beat & ~mon_sop & mon_eop & in_frame & len_ok;
        bad_end  = (sop_beat & (in_frame | mon_eop))
                 | (beat & ~mon_sop & mon_eop & in_frame & ~len_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            in_frame <= 1'b0;
        end else if (sop_beat) begin
            beat_cnt <= 9'd1;
            in_frame <= ~mon_eop;
        end else if (beat && in_frame) begin
            if (mon_eop)
                in_frame <= 1'b0;
            else if (beat_cnt != 9'h1FF)
                beat_cnt <= beat_cnt + 9'd1;
        end
    end

endmodule

// File: rtl/bkg_sub_sequencer.sv
// Frame-level sequencer: bypass -> RAM clear -> accumulate -> apply.
// Optional automatic recalibration in APPLY when BKG_AUTO_RECAL_EN is defined.
module bkg_sub_sequencer
    import bkg_sub_pkg::*;
#(
    parameter int BKG_FRAME       = 4,
    parameter int WORDS_PER_FRAME = WORDS_PER_FRAME_DEF,
    parameter int FRAME_ID_W      = 27,
    parameter int RECAL_PERIOD    = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mon_valid,
    input  logic                  mon_ready,
    input  logic                  mon_sop,
    input  logic                  mon_eop,
    input  logic                  cmd_enable,
    input  logic                  cmd_recal,
    output logic [1:0]            frame_mode,
    output logic                  bkg_sub_on,
    output logic                  bkg_valid,
    output logic [7:0]            accum_cnt,
    output logic [7:0]            bkg_epoch,
    output logic [FRAME_ID_W-1:0] frame_id,
    output logic                  frame_err,
    output logic [15:0]           err_cnt,
    output logic                  recal_pending
);

    logic   sop_beat, good_end, bad_end;
    state_t state, state_n;
    mode_t  mode_q, mode_n;
    logic [7:0] acc_n, epoch_n;
    logic   valid_n, recal_p, recal_n, dis_p, dis_n;

`ifdef BKG_AUTO_RECAL_EN
    logic [31:0] apply_cnt, apply_cnt_n;
`else
    localparam int unused_recal_period = RECAL_PERIOD;
`endif

    bkg_frame_checker #(.WORDS_PER_FRAME(WORDS_PER_FRAME)) u_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .mon_valid (mon_valid),
        .mon_ready (mon_ready),
        .mon_sop   (mon_sop),
        .mon_eop   (mon_eop),
        .sop_beat  (sop_beat),
        .good_end  (good_end),
        .bad_end   (bad_end)
    );

    assign frame_mode = mode_q;

    // Order within a cycle: frame-end transition, then requests, then SOP commit.
    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        acc_n   = accum_cnt;
        epoch_n = bkg_epoch;
        valid_n = bkg_valid;
        recal_n = recal_p;
        dis_n   = dis_p;
`ifdef BKG_AUTO_RECAL_EN
        apply_cnt_n = apply_cnt;
`endif

        if (good_end) begin
            case (state)
                ST_CLEAR: begin
                    state_n = ST_ACCUM;
                    acc_n   = '0;
                end
                ST_ACCUM: begin
                    acc_n = accum_cnt + 8'd1;
                    if (({1'b0, accum_cnt} + 9'd1) == 9'(BKG_FRAME)) begin
                        state_n = ST_APPLY;
                        valid_n = 1'b1;
                        epoch_n = bkg_epoch + 8'd1;
                    end
                end
                default: ;
            endcase
        end
        if (bad_end && state == ST_ACCUM) begin
            state_n = ST_CLEAR;
            acc_n   = '0;
        end

`ifdef BKG_AUTO_RECAL_EN
        if (state == ST_APPLY && good_end) begin
            if ((apply_cnt + 32'd1) == 32'(RECAL_PERIOD)) begin
                recal_n     = 1'b1;
                apply_cnt_n = '0;
            end else begin
                apply_cnt_n = apply_cnt + 32'd1;
            end
        end
        if (state_n != ST_APPLY)
            apply_cnt_n = '0;
`endif

        if (cmd_recal && state_n != ST_IDLE)
            recal_n = 1'b1;
        dis_n = ~cmd_enable & (state_n != ST_IDLE);

        if (sop_beat) begin
            if (dis_n) begin
                state_n = ST_IDLE;
                mode_n  = MODE_BYPASS;
                valid_n = 1'b0;
                acc_n   = '0;
                dis_n   = 1'b0;
                recal_n = 1'b0;
            end else if (recal_n) begin
                state_n = ST_CLEAR;
                mode_n  = MODE_CLEAR;
                valid_n = 1'b0;
                acc_n   = '0;
                recal_n = 1'b0;
            end else if (state_n == ST_IDLE) begin
                if (cmd_enable) begin
                    state_n = ST_CLEAR;
                    mode_n  = MODE_CLEAR;
                end else begin
                    mode_n  = MODE_BYPASS;
                end
            end else begin
                mode_n = mode_of(state_n);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            mode_q        <= MODE_BYPASS;
            bkg_sub_on    <= 1'b0;
            bkg_valid     <= 1'b0;
            accum_cnt     <= '0;
            bkg_epoch     <= '0;
            frame_id      <= '0;
            frame_err     <= 1'b0;
            err_cnt       <= '0;
            recal_p       <= 1'b0;
            dis_p         <= 1'b0;
            recal_pending <= 1'b0;
`ifdef BKG_AUTO_RECAL_EN
            apply_cnt     <= '0;
`endif
        end else begin
            state         <= state_n;
            mode_q        <= mode_n;
            bkg_sub_on    <= (mode_n == MODE_APPLY);
            bkg_valid     <= valid_n;
            accum_cnt     <= acc_n;
            bkg_epoch     <= epoch_n;
            frame_err     <= bad_end;
            recal_p       <= recal_n;
            dis_p         <= dis_n;
            recal_pending <= recal_n | dis_n;
            if (sop_beat)
                frame_id <= frame_id + 1'b1;
            if (bad_end && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
`ifdef BKG_AUTO_RECAL_EN
            apply_cnt     <= apply_cnt_n;
`endif
        end
    end

endmodule
